// File: rtl/gap_channel_scheduler.sv
// Streams each feature-map channel through a shared global-average-pool
// unit and hands tagged per-channel results downstream over valid/ready.
module gap_channel_scheduler #(
    parameter int IMG_W  = 14,
    parameter int IMG_H  = 14,
    parameter int NUM_CH = 8,
    parameter int ADDR_W = 16,
    parameter int CH_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              fm_rd_en,
    output logic [ADDR_W-1:0] fm_rd_addr,
    input  logic [7:0]        fm_rd_data,
    output logic [7:0]        pool_in_data,
    output logic              pool_in_valid,
    output logic              pool_clr_n,
    input  logic [7:0]        pool_out_data,
    input  logic              pool_out_valid,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic [7:0]        res_data
);

    localparam int P     = IMG_W * IMG_H;
    localparam int PIX_W = $clog2(P);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state;
    logic [PIX_W-1:0]  pix;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   out_ch;
    logic [ADDR_W-1:0] addr;

    logic hs;
    logic last_pix;
    logic stall;
    logic capture;

    assign hs       = res_valid & res_ready;
    assign last_pix = (pix == PIX_W'(P - 1));
    // Hold the channel's final read until the previous result can leave.
    assign stall    = last_pix & res_valid & ~res_ready;
    assign capture  = pool_out_valid & (state != IDLE);

    assign busy         = (state != IDLE);
    assign pool_in_data = fm_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            done          <= 1'b0;
            fm_rd_en      <= 1'b0;
            fm_rd_addr    <= '0;
            pool_in_valid <= 1'b0;
            pool_clr_n    <= 1'b0;
            res_valid     <= 1'b0;
            res_ch        <= '0;
            res_data      <= '0;
            pix           <= '0;
            ch            <= '0;
            out_ch        <= '0;
            addr          <= '0;
        end else if (abort) begin
            state         <= IDLE;
            done          <= 1'b0;
            fm_rd_en      <= 1'b0;
            pool_in_valid <= 1'b0;
            pool_clr_n    <= 1'b0;
            res_valid     <= 1'b0;
        end else begin
            pool_clr_n    <= 1'b1;
            done          <= 1'b0;
            fm_rd_en      <= 1'b0;
            pool_in_valid <= fm_rd_en;

            if (capture) begin
                res_data  <= pool_out_data;
                res_ch    <= out_ch;
                res_valid <= 1'b1;
                out_ch    <= out_ch + 1'b1;
            end else if (hs) begin
                res_valid <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= ISSUE;
                        pix    <= '0;
                        ch     <= '0;
                        out_ch <= '0;
                        addr   <= '0;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        fm_rd_en   <= 1'b1;
                        fm_rd_addr <= addr;
                        addr       <= addr + 1'b1;
                        if (last_pix) begin
                            pix <= '0;
                            if (ch == CH_W'(NUM_CH - 1))
                                state <= DRAIN;
                            else
                                ch <= ch + 1'b1;
                        end else begin
                            pix <= pix + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ch == CH_W'(NUM_CH) && (!res_valid || res_ready)) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gap_channel_scheduler.sv
// Random-data frames against a reference list of per-channel pool results,
// with a behavioural feature buffer and reciprocal-multiply pool unit.
module tb_gap_channel_scheduler;

    localparam int IMG_W  = 14;
    localparam int IMG_H  = 14;
    localparam int NUM_CH = 4;
    localparam int ADDR_W = 16;
    localparam int CH_W   = 4;
    localparam int P      = IMG_W * IMG_H;
    localparam int N      = NUM_CH * P;
    localparam int RECIP  = 65536 / P;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              fm_rd_en;
    logic [ADDR_W-1:0] fm_rd_addr;
    logic [7:0]        fm_rd_data = '0;
    logic [7:0]        pool_in_data;
    logic              pool_in_valid;
    logic              pool_clr_n;
    logic [7:0]        pool_out_data;
    logic              pool_out_valid;
    logic              res_valid;
    logic              res_ready;
    logic [CH_W-1:0]   res_ch;
    logic [7:0]        res_data;

    logic [7:0] fm [N];
    int         psum = 0;
    int         pcnt = 0;
    logic       pov  = 1'b0;
    logic [7:0] pod  = '0;
    logic       inj  = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    gap_channel_scheduler #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr),
        .fm_rd_data(fm_rd_data),
        .pool_in_data(pool_in_data), .pool_in_valid(pool_in_valid),
        .pool_clr_n(pool_clr_n),
        .pool_out_data(pool_out_data), .pool_out_valid(pool_out_valid),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_data(res_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (fm_rd_en && int'(fm_rd_addr) < N)
            fm_rd_data <= fm[fm_rd_addr];

    // Pool unit: sums P samples, result = sum * floor(65536/P) >> 16.
    always @(posedge clk) begin
        if (!pool_clr_n) begin
            psum <= 0;
            pcnt <= 0;
            pov  <= 1'b0;
        end else begin
            pov <= 1'b0;
            if (pool_in_valid) begin
                if (pcnt == P - 1) begin
                    pod  <= 8'(((psum + int'(pool_in_data)) * RECIP) >>> 16);
                    pov  <= 1'b1;
                    psum <= 0;
                    pcnt <= 0;
                end else begin
                    psum <= psum + int'(pool_in_data);
                    pcnt <= pcnt + 1;
                end
            end
        end
    end

    assign pool_out_valid = pov | inj;
    assign pool_out_data  = pod;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_for(input int c);
        int sum;
        sum = 0;
        for (int i = 0; i < P; i++) sum += int'(fm[c * P + i]);
        return (sum * RECIP) >>> 16;
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < N; i++) begin
            case (pat)
                0: fm[i] = 8'd100;
                1: fm[i] = (i < P) ? 8'd255 : (i < 2 * P) ? 8'd0
                                            : 8'($urandom);
                default: fm[i] = 8'($urandom);
            endcase
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", fm_rd_en, 0);
        chk("rst_addr", fm_rd_addr, 0);
        chk("rst_pin_valid", pool_in_valid, 0);
        chk("rst_clr_n", pool_clr_n, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_ch", res_ch, 0);
        chk("rst_res_data", res_data, 0);
    endtask

    // mode: 0 ready=1, 1 ready=0 for 500 cycles, 2 random ready
    task automatic run_frame(input int mode, input int abort_at,
                             input int rst_at, input int restart_at,
                             input bit full);
        logic [11:0] got_q[$];
        int   rise_q[$];
        int   exp_addr, nrd, done_k, done_seen, last_addr, lim;
        bit   rdy, prev_valid, prev_hold;
        logic [11:0] prev_res;
        exp_addr = 0; nrd = 0; done_k = -1; done_seen = 0;
        last_addr = -1; prev_valid = 0; prev_hold = 0; prev_res = '0;
        lim = full ? 3000 : ((abort_at >= 0 ? abort_at : rst_at) + 20);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < lim; k++) begin
            if (k == 0) chk("busy_start", busy, 1);
            if (fm_rd_en) begin
                chk("rd_addr", fm_rd_addr, exp_addr);
                exp_addr++;
                nrd++;
                last_addr = int'(fm_rd_addr);
            end
            if (prev_hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_res", {res_ch, res_data}, prev_res);
            end
            if (res_valid && !prev_valid) rise_q.push_back(k);
            prev_valid = res_valid;
            if (done) begin
                done_seen++;
                done_k = k;
                chk("busy_at_done", busy, 0);
            end
            if (mode == 1 && k == 499) begin
                chk("stall_addr", last_addr, 390);
                chk("stall_data", res_data, exp_for(0));
                chk("stall_ch", res_ch, 0);
            end
            if (abort_at >= 0 && k == abort_at + 1) begin
                chk("abort_busy", busy, 0);
                chk("abort_clr_n", pool_clr_n, 0);
                chk("abort_res_valid", res_valid, 0);
                chk("abort_rd_en", fm_rd_en, 0);
                chk("abort_pin_valid", pool_in_valid, 0);
            end
            if (rst_at >= 0 && k == rst_at + 1) chk_reset_vals();
            if ((abort_at >= 0 && k == abort_at + 2) ||
                (rst_at >= 0 && k == rst_at + 2))
                chk("clr_n_release", pool_clr_n, 1);
            if (done_k >= 0 && k == done_k + 1) begin
                chk("done_width", done, 0);
                break;
            end
            case (mode)
                0: rdy = 1'b1;
                1: rdy = (k >= 500);
                default: rdy = ($urandom_range(0, 3) != 0);
            endcase
            res_ready = rdy;
            start = (k == restart_at);
            abort = (k == abort_at);
            rst_n = !(k == rst_at);
            prev_hold = res_valid && !rdy && !abort && rst_n;
            prev_res = {res_ch, res_data};
            if (res_valid && rdy) got_q.push_back({res_ch, res_data});
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        rst_n = 1'b1;
        if (!full) begin
            chk("no_done", done_seen, 0);
            return;
        end
        chk("done_seen", done_seen, 1);
        chk("n_res", got_q.size(), NUM_CH);
        for (int i = 0; i < got_q.size() && i < NUM_CH; i++) begin
            chk("res_tag", got_q[i][11:8], i);
            chk("res_data", got_q[i][7:0], exp_for(i));
        end
        chk("n_rd", nrd, N);
        if (mode == 0) begin
            chk("done_cyc", done_k, NUM_CH * P + 4);
            for (int i = 0; i < rise_q.size() && i < NUM_CH; i++)
                chk("valid_cyc", rise_q[i], (i + 1) * P + 3);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        chk("clr_n_after_rst", pool_clr_n, 1);

        fill(0);
        run_frame(0, -1, -1, -1, 1);
        fill(1);
        run_frame(0, -1, -1, -1, 1);
        fill(0);
        run_frame(1, -1, -1, -1, 1);

        fill(2);
        run_frame(0, 300, -1, -1, 0);
        fill(2);
        run_frame(2, -1, -1, -1, 1);

        fill(2);
        run_frame(0, -1, 250, -1, 0);
        fill(2);
        run_frame(2, -1, -1, -1, 1);

        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("idle_pov_ignored", res_valid, 0);
        chk("idle_busy", busy, 0);
        fill(2);
        run_frame(0, -1, -1, 50, 1);

        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_clr_n", pool_clr_n, 0);
        @(negedge clk);
        chk("idle_abort_clr_rel", pool_clr_n, 1);

        repeat (2) begin
            fill(2);
            run_frame(2, -1, -1, -1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
